// File: rtl/delay_cal_pkg.sv
// Shared definitions for the delay tap calibrator: FSM encoding, default tap width,
// error-counter width and the window-centre helper.
package delay_cal_pkg;

    localparam int TAP_WIDTH_DEFAULT = 9;
    localparam int ERR_WIDTH         = 8;

    typedef logic [TAP_WIDTH_DEFAULT-1:0] t_tap;
    typedef logic [2:0]                   t_state;

    localparam t_state ST_IDLE    = 3'd0;
    localparam t_state ST_LOAD    = 3'd1;
    localparam t_state ST_SETTLE  = 3'd2;
    localparam t_state ST_SAMPLE  = 3'd3;
    localparam t_state ST_EVAL    = 3'd4;
    localparam t_state ST_FINAL   = 3'd5;
    localparam t_state ST_FSETTLE = 3'd6;
    localparam t_state ST_DONE    = 3'd7;

    // Floor centre of a window; an empty window (len 0, start 0) yields tap 0.
    function automatic int unsigned window_centre(input int unsigned start, input int unsigned len);
        return start + (len >> 1);
    endfunction

endpackage

// File: rtl/delay_tap_calibrator_tracker.sv
// Tracks the current run of passing taps and keeps the longest closed run seen so far;
// ties keep the earlier window because replacement needs a strictly longer run.
module eye_window_tracker
    import delay_cal_pkg::*;
#(
    parameter int TAP_WIDTH = TAP_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 eval_valid,
    input  logic                 pass,
    input  logic [TAP_WIDTH-1:0] tap,
    input  logic                 last,
    output logic [TAP_WIDTH-1:0] best_start,
    output logic [TAP_WIDTH:0]   best_len
);

    logic [TAP_WIDTH-1:0] cur_start_reg;
    logic [TAP_WIDTH:0]   cur_len_reg;
    logic [TAP_WIDTH-1:0] best_start_reg;
    logic [TAP_WIDTH:0]   best_len_reg;

    logic [TAP_WIDTH-1:0] run_start;
    logic [TAP_WIDTH:0]   run_len;
    logic                 closing;
    logic [TAP_WIDTH-1:0] closed_start;
    logic [TAP_WIDTH:0]   closed_len;

    always_comb begin
        run_start    = (cur_len_reg == '0) ? tap : cur_start_reg;
        run_len      = cur_len_reg + {{TAP_WIDTH{1'b0}}, 1'b1};
        // A pass on the last tap closes the run too: no wrap-around to tap 0.
        closing      = eval_valid && (!pass || last);
        closed_start = pass ? run_start : cur_start_reg;
        closed_len   = pass ? run_len : cur_len_reg;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cur_start_reg  <= '0;
            cur_len_reg    <= '0;
            best_start_reg <= '0;
            best_len_reg   <= '0;
        end else if (eval_valid) begin
            if (closing) begin
                cur_start_reg <= '0;
                cur_len_reg   <= '0;
                if (closed_len > best_len_reg) begin
                    best_start_reg <= closed_start;
                    best_len_reg   <= closed_len;
                end
            end else begin
                cur_start_reg <= run_start;
                cur_len_reg   <= run_len;
            end
        end
    end

    assign best_start = best_start_reg;
    assign best_len   = best_len_reg;

endmodule

// File: rtl/delay_tap_calibrator.sv
// Sweeps every tap of a cascaded delay line, scores each against the training bit,
// then loads the centre of the longest passing window.
module delay_tap_calibrator
    import delay_cal_pkg::*;
#(
    parameter int TAP_WIDTH     = TAP_WIDTH_DEFAULT,
    parameter int MAX_TAP       = 511,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 64,
    parameter int ERR_THRESHOLD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cal_start,
    input  logic                 data_sample,
    input  logic                 expected_bit,
    output logic                 delay_load,
    output logic [TAP_WIDTH-1:0] delay__value,
    output logic                 cal_busy,
    output logic                 cal_done,
    output logic                 cal_fail,
    output logic [TAP_WIDTH-1:0] eye_start,
    output logic [TAP_WIDTH:0]   eye_width
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [TAP_WIDTH-1:0] LAST_TAP    = TAP_WIDTH'(MAX_TAP);
    localparam logic [ERR_WIDTH-1:0] ERR_LIMIT   =
        ERR_WIDTH'((ERR_THRESHOLD > 255) ? 255 : ERR_THRESHOLD);

    t_state               state_reg;
    t_state               state_next;
    logic [TAP_WIDTH-1:0] tap_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [ERR_WIDTH-1:0] err_reg;
    logic [TAP_WIDTH-1:0] hold_value_reg;
    logic                 fail_reg;
    logic [TAP_WIDTH-1:0] eye_start_reg;
    logic [TAP_WIDTH:0]   eye_width_reg;

    logic                 at_last_tap;
    logic                 tap_pass;
    logic                 eval_valid;
    logic                 accept;
    logic [TAP_WIDTH-1:0] best_start;
    logic [TAP_WIDTH:0]   best_len;
    logic [TAP_WIDTH-1:0] centre;

    assign at_last_tap = (tap_reg == LAST_TAP);
    assign tap_pass    = (err_reg <= ERR_LIMIT);
    assign eval_valid  = (state_reg == ST_EVAL);
    assign accept      = cal_start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign centre      = TAP_WIDTH'(window_centre(32'(best_start), 32'(best_len)));

    eye_window_tracker #(
        .TAP_WIDTH (TAP_WIDTH)
    ) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .eval_valid (eval_valid),
        .pass       (tap_pass),
        .tap        (tap_reg),
        .last       (at_last_tap),
        .best_start (best_start),
        .best_len   (best_len)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: if (cal_start) state_next = ST_LOAD;
            ST_LOAD:          state_next = ST_SETTLE;
            ST_SETTLE:        if (cnt_reg == SETTLE_LAST) state_next = ST_SAMPLE;
            ST_SAMPLE:        if (cnt_reg == SAMPLE_LAST) state_next = ST_EVAL;
            ST_EVAL:          state_next = at_last_tap ? ST_FINAL : ST_LOAD;
            ST_FINAL:         state_next = ST_FSETTLE;
            ST_FSETTLE:       if (cnt_reg == SETTLE_LAST) state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            tap_reg        <= '0;
            cnt_reg        <= '0;
            err_reg        <= '0;
            hold_value_reg <= '0;
            fail_reg       <= 1'b0;
            eye_start_reg  <= '0;
            eye_width_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (cal_start) begin
                        tap_reg  <= '0;
                        fail_reg <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    hold_value_reg <= tap_reg;
                    cnt_reg        <= '0;
                    err_reg        <= '0;
                end
                ST_SETTLE, ST_FSETTLE: begin
                    cnt_reg <= (cnt_reg == SETTLE_LAST) ? '0
                             : cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                ST_SAMPLE: begin
                    cnt_reg <= (cnt_reg == SAMPLE_LAST) ? '0
                             : cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                    if ((data_sample != expected_bit) && (err_reg != '1))
                        err_reg <= err_reg + 8'd1;
                end
                ST_EVAL: begin
                    if (!at_last_tap)
                        tap_reg <= tap_reg + {{(TAP_WIDTH-1){1'b0}}, 1'b1};
                end
                ST_FINAL: begin
                    hold_value_reg <= centre;
                    cnt_reg        <= '0;
                    fail_reg       <= (best_len == '0);
                    eye_start_reg  <= (best_len == '0) ? '0 : best_start;
                    eye_width_reg  <= best_len;
                end
                default: ;
            endcase
        end
    end

    // The strobe cycle drives the fresh value directly; afterwards the held copy keeps it stable.
    always_comb begin
        delay__value = hold_value_reg;
        if (state_reg == ST_LOAD)
            delay__value = tap_reg;
        else if (state_reg == ST_FINAL)
            delay__value = centre;
    end

    assign delay_load = (state_reg == ST_LOAD) || (state_reg == ST_FINAL);
    assign cal_busy   = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign cal_done   = (state_reg == ST_DONE);
    assign cal_fail   = fail_reg;
    assign eye_start  = eye_start_reg;
    assign eye_width  = eye_width_reg;

endmodule
